// File: rtl/game_timer.sv
// ---------------------------------------------------------------------------
// game_timer
//   Timing front end for the snake game. Generates the free-running pwm_base
//   square wave, a one-cycle frame strobe per vsync rising edge, and runs the
//   game state machine (IDLE, COUNTDOWN, RUN, PAUSE, OVER). In RUN it issues
//   a one-cycle game tick every `period` frames; the period shrinks as the
//   snake eats and speed rises.
//
// Ports
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   vsync        in   frame sync level from VGA timing, active high
//   start        in   one-cycle start/restart request
//   eat          in   one-cycle, snake ate food
//   failure      in   one-cycle, collision
//   pause_toggle in   one-cycle pause/resume request
//   pwm_base     out  square wave, period 2*PWM_DIV clk
//   frame        out  one-cycle strobe per vsync rising edge
//   tick         out  one-cycle game step (RUN only, coincides with frame)
//   speed        out  current speed level
//   running      out  state == RUN
//   paused       out  state == PAUSE
//   game_over    out  state == OVER
// ---------------------------------------------------------------------------
module game_timer #(
   parameter int unsigned PWM_DIV          = 394,
   parameter int unsigned BASE_FRAMES      = 30,
   parameter int unsigned STEP             = 2,
   parameter int unsigned MIN_FRAMES       = 6,
   parameter int unsigned MAX_SPEED        = 15,
   parameter int unsigned COUNTDOWN_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic       start,
   input  logic       eat,
   input  logic       failure,
   input  logic       pause_toggle,
   output logic       pwm_base,
   output logic       frame,
   output logic       tick,
   output logic [3:0] speed,
   output logic       running,
   output logic       paused,
   output logic       game_over
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNTDOWN,
      S_RUN,
      S_PAUSE,
      S_OVER
   } state_t;

   state_t      r_state;
   logic [15:0] r_div_cnt;
   logic        r_pwm;
   logic        r_vsync_q;
   logic        r_frame;
   logic        r_tick;
   logic [3:0]  r_speed;
   logic [7:0]  r_frame_cnt;
   logic [7:0]  r_cd_cnt;

   logic        w_edge;
   logic [7:0]  w_step_total;
   logic [7:0]  w_period;
   logic        w_period_done;

   // Rising edge of vsync, seen in the cycle vsync is first sampled high.
   assign w_edge = vsync & ~r_vsync_q;

   // speed*STEP is at most 15*15 = 225, so 8 bits never overflow. Clamping
   // before the subtraction keeps the period from underflowing.
   assign w_step_total = 8'(r_speed) * 8'(STEP);
   assign w_period     = (w_step_total > 8'(BASE_FRAMES - MIN_FRAMES))
                         ? 8'(MIN_FRAMES)
                         : 8'(BASE_FRAMES) - w_step_total;

   // A frame count already past the end of a freshly shortened period is
   // treated as due, so a burst of eats can never make the count wrap.
   assign w_period_done = (r_frame_cnt >= (w_period - 8'd1));

   // pwm_base divider: runs in every state.
   // NOTE: every clocked block uses non-blocking (<=) assignments so all
   // registers update from the values present before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
         r_pwm     <= 1'b0;
      end else if (r_div_cnt == 16'(PWM_DIV - 1)) begin
         r_div_cnt <= '0;
         r_pwm     <= ~r_pwm;
      end else begin
         r_div_cnt <= r_div_cnt + 16'd1;
      end
   end

   // vsync edge detect. r_vsync_q resets high so vsync already high at
   // reset release is not mistaken for a new frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vsync_q <= 1'b1;
         r_frame   <= 1'b0;
      end else begin
         r_vsync_q <= vsync;
         r_frame   <= w_edge;
      end
   end

   // Game state machine. Priority: failure > start > pause_toggle > eat >
   // frame processing; in RUN eat and frame processing both act.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_tick      <= 1'b0;
         r_speed     <= '0;
         r_frame_cnt <= '0;
         r_cd_cnt    <= '0;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state  <= S_COUNTDOWN;
                  r_cd_cnt <= 8'(COUNTDOWN_FRAMES);
                  r_speed  <= '0;
               end
            end

            S_COUNTDOWN: begin
               if (failure) begin
                  r_state <= S_OVER;
               end else if (start) begin
                  r_cd_cnt <= 8'(COUNTDOWN_FRAMES);
                  r_speed  <= '0;
               end else if (w_edge) begin
                  if (r_cd_cnt == 8'd1) begin
                     r_state     <= S_RUN;
                     r_frame_cnt <= '0;
                  end else begin
                     r_cd_cnt <= r_cd_cnt - 8'd1;
                  end
               end
            end

            S_RUN: begin
               if (failure) begin
                  r_state <= S_OVER;
               end else if (start) begin
                  r_state  <= S_COUNTDOWN;
                  r_cd_cnt <= 8'(COUNTDOWN_FRAMES);
                  r_speed  <= '0;
               end else if (pause_toggle) begin
                  r_state <= S_PAUSE;
               end else begin
                  if (eat && (r_speed < 4'(MAX_SPEED))) begin
                     r_speed <= r_speed + 4'd1;
                  end
                  // w_period reflects the speed before this cycle's eat.
                  if (w_edge) begin
                     if (w_period_done) begin
                        r_tick      <= 1'b1;
                        r_frame_cnt <= '0;
                     end else begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                     end
                  end
               end
            end

            S_PAUSE: begin
               if (failure) begin
                  r_state <= S_OVER;
               end else if (start) begin
                  r_state  <= S_COUNTDOWN;
                  r_cd_cnt <= 8'(COUNTDOWN_FRAMES);
                  r_speed  <= '0;
               end else if (pause_toggle) begin
                  r_state <= S_RUN;
               end
            end

            S_OVER: begin
               if (start) begin
                  r_state  <= S_COUNTDOWN;
                  r_cd_cnt <= 8'(COUNTDOWN_FRAMES);
                  r_speed  <= '0;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pwm_base  = r_pwm;
   assign frame     = r_frame;
   assign tick      = r_tick;
   assign speed     = r_speed;
   assign running   = (r_state == S_RUN);
   assign paused    = (r_state == S_PAUSE);
   assign game_over = (r_state == S_OVER);

endmodule
